// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds the register-number and data widths and the queued write entry type.
package rf_arb_pkg;

    localparam int unsigned REG_NUM_W = 3;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_REGS  = 8;

    // One queued aux write. valid drops when a newer W write to the same register supersedes it.
    typedef struct packed {
        logic                 valid;
        logic [REG_NUM_W-1:0] reg_num;
        logic [DATA_W-1:0]    data;
    } rf_wr_entry_t;

endpackage

// File: rtl/rf_aux_fifo.sv
// Aux write queue: storage, wrapping pointers, per-entry cancel by register number and the
// pending-write mask reduction.
// Ports:
//   Clk, Reset              clock, synchronous active-low reset
//   push, push_reg/data     enqueue a valid entry at the tail (caller guarantees !full)
//   pop                     drop the head slot (caller guarantees !empty)
//   cancel_en, cancel_reg   clear valid of every stored entry targeting cancel_reg
//   full, empty, head       occupancy flags and head slot contents
//   cancel_hit              at least one live entry is being cancelled this cycle
//   pending_mask            onehot OR of the registers of all live entries
module rf_aux_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 push,
    input  logic [REG_NUM_W-1:0] push_reg,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 pop,
    input  logic                 cancel_en,
    input  logic [REG_NUM_W-1:0] cancel_reg,
    output logic                 full,
    output logic                 empty,
    output rf_wr_entry_t         head,
    output logic                 cancel_hit,
    output logic [NUM_REGS-1:0]  pending_mask
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    rf_wr_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [Depth-1:0] cancel_vec;

    // Unoccupied slots always hold valid=0, so the reductions can scan every slot.
    always_comb begin
        cancel_vec   = '0;
        pending_mask = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            cancel_vec[i] = cancel_en && mem_q[i].valid && (mem_q[i].reg_num == cancel_reg);
            if (mem_q[i].valid) begin
                pending_mask[mem_q[i].reg_num] = 1'b1;
            end
        end
    end

    assign cancel_hit = |cancel_vec;
    assign full       = (count_q == CntW'(Depth));
    assign empty      = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (cancel_vec[i]) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q              <= rd_ptr_q + PtrW'(1);
            end
            // A push lands after the cancel scan, so an aux write racing a W write to the
            // same register stays valid (aux is treated as the newer value).
            if (push) begin
                mem_q[wr_ptr_q] <= '{valid: 1'b1, reg_num: push_reg, data: push_data};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the writeback stage (W, always wins) and an
// aux requester (A, queued and drained in idle WB cycles).
// Ports:
//   Clk, Reset                       clock, synchronous active-low reset
//   WB_Valid/WB_Reg/WB_Data          writeback write request
//   Aux_Valid/Aux_Reg/Aux_Data       aux write request, accepted when Aux_Ready
//   Aux_Ready                        queue not full
//   RF_RegWrite/RF_Write_Reg/Data    registered write to the register file
//   Pending_Mask                     registers with a live queued aux write
//   Pipe_Stall                       queue head starved; hold WB_Valid low next cycle
//   Conflict                         pulse: a queued entry was superseded by W
//   Proto_Err                        sticky: WB_Valid seen while Pipe_Stall high
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WAIT   = 7
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 WB_Valid,
    input  logic [REG_NUM_W-1:0] WB_Reg,
    input  logic [DATA_W-1:0]    WB_Data,
    input  logic                 Aux_Valid,
    input  logic [REG_NUM_W-1:0] Aux_Reg,
    input  logic [DATA_W-1:0]    Aux_Data,
    output logic                 Aux_Ready,
    output logic                 RF_RegWrite,
    output logic [REG_NUM_W-1:0] RF_Write_Reg,
    output logic [DATA_W-1:0]    RF_Write_Data,
    output logic [NUM_REGS-1:0]  Pending_Mask,
    output logic                 Pipe_Stall,
    output logic                 Conflict,
    output logic                 Proto_Err
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    logic         fifo_full, fifo_empty, fifo_cancel_hit;
    rf_wr_entry_t fifo_head;
    logic         push, pop;

    logic                 rf_we_d, rf_we_q;
    logic [REG_NUM_W-1:0] rf_reg_d, rf_reg_q;
    logic [DATA_W-1:0]    rf_data_d, rf_data_q;
    logic [WaitW-1:0]     wait_d, wait_q;
    logic                 stall_q, conflict_q, proto_err_q;

    rf_aux_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .Clk          (Clk),
        .Reset        (Reset),
        .push         (push),
        .push_reg     (Aux_Reg),
        .push_data    (Aux_Data),
        .pop          (pop),
        .cancel_en    (WB_Valid),
        .cancel_reg   (WB_Reg),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .head         (fifo_head),
        .cancel_hit   (fifo_cancel_hit),
        .pending_mask (Pending_Mask)
    );

    // No push-through when full, even if the head pops this cycle.
    assign Aux_Ready = !fifo_full;
    assign push      = Aux_Valid && !fifo_full;
    // Any idle WB cycle pops the head, including cancelled heads (no write, one cycle lost).
    assign pop       = !WB_Valid && !fifo_empty;

    always_comb begin
        rf_we_d   = 1'b0;
        rf_reg_d  = '0;
        rf_data_d = '0;
        if (WB_Valid) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = WB_Reg;
            rf_data_d = WB_Data;
        end else if (pop && fifo_head.valid) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = fifo_head.reg_num;
            rf_data_d = fifo_head.data;
        end
    end

    // Starvation: count cycles a valid head loses to W; a cancelled head neither counts nor
    // clears until it is popped.
    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (WB_Valid && fifo_head.valid && (wait_q != WaitMax)) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rf_we_q     <= 1'b0;
            rf_reg_q    <= '0;
            rf_data_q   <= '0;
            wait_q      <= '0;
            stall_q     <= 1'b0;
            conflict_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_reg_q    <= rf_reg_d;
            rf_data_q   <= rf_data_d;
            wait_q      <= wait_d;
            stall_q     <= (wait_d == WaitMax);
            conflict_q  <= fifo_cancel_hit;
            proto_err_q <= proto_err_q | (WB_Valid & stall_q);
        end
    end

    assign RF_RegWrite   = rf_we_q;
    assign RF_Write_Reg  = rf_reg_q;
    assign RF_Write_Data = rf_data_q;
    assign Pipe_Stall    = stall_q;
    assign Conflict      = conflict_q;
    assign Proto_Err     = proto_err_q;

endmodule
